// File: rtl/axis_frame_length_filter.sv
// AXI4-Stream frame length policer: counts beats, truncates over-long frames and
// marks short or truncated frames bad via tuser on the final beat, one register stage.
module axis_frame_length_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  frame_done,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  error_short,
  output logic                  error_long
);
  localparam logic ST_PASS  = 1'b0;
  localparam logic ST_TRUNC = 1'b1;
  localparam logic [LEN_WIDTH-1:0] CNT_SAT = '1;
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  logic                 state;
  logic                 first_q;
  logic [LEN_WIDTH-1:0] cnt_q, min_q, max_q;

  logic [LEN_WIDTH-1:0] cur_min, cur_max, beat_idx;
  logic                 accept, load, is_trunc, is_short;

  // Limits apply from the first beat of a frame; mid-frame edits wait for the next one.
  assign cur_min  = first_q ? length_min : min_q;
  assign cur_max  = first_q ? length_max : max_q;
  assign beat_idx = first_q ? ONE : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + ONE);

  assign input_axis_tready = (state == ST_TRUNC) | output_axis_tready | ~output_axis_tvalid;
  assign accept   = input_axis_tvalid & input_axis_tready;
  assign load     = accept & (state == ST_PASS);
  // Truncation needs a non-final beat, so it can never coincide with a short frame.
  assign is_trunc = load & (cur_max != '0) & (beat_idx == cur_max) & ~input_axis_tlast;
  assign is_short = input_axis_tlast & (cur_min > ONE) & (beat_idx < cur_min);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_PASS;
      first_q            <= 1'b1;
      cnt_q              <= '0;
      min_q              <= '0;
      max_q              <= '0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
      frame_done         <= 1'b0;
      frame_len          <= '0;
      error_short        <= 1'b0;
      error_long         <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      error_short <= 1'b0;
      error_long  <= 1'b0;
      if (load) begin
        output_axis_tdata  <= input_axis_tdata;
        output_axis_tvalid <= 1'b1;
        output_axis_tlast  <= input_axis_tlast | is_trunc;
        output_axis_tuser  <= input_axis_tuser | is_short | is_trunc;
        cnt_q              <= beat_idx;
        first_q            <= input_axis_tlast;
        if (first_q) begin
          min_q <= length_min;
          max_q <= length_max;
        end
        if (input_axis_tlast | is_trunc) begin
          frame_done  <= 1'b1;
          frame_len   <= beat_idx;
          error_short <= is_short;
          error_long  <= is_trunc;
        end
        if (is_trunc) state <= ST_TRUNC;
      end else if (output_axis_tready) begin
        output_axis_tvalid <= 1'b0;
      end
      // Tail of a truncated frame is swallowed up to and including its tlast.
      if (accept && state == ST_TRUNC && input_axis_tlast) begin
        state   <= ST_PASS;
        first_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_frame_length_filter.sv
// Directed bench for axis_frame_length_filter: table of single-frame vectors plus
// hand-written latency, back-to-back, backpressure, mid-frame-limit and reset sequences.
module tb_axis_frame_length_filter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_user = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_user;
  logic        out_ready = 1'b1;
  logic [15:0] length_min = '0, length_max = '0;
  logic        frame_done, error_short, error_long;
  logic [15:0] frame_len;

  axis_frame_length_filter #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid), .input_axis_tready(in_ready),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user),
    .output_axis_tdata(out_data), .output_axis_tvalid(out_valid), .output_axis_tready(out_ready),
    .output_axis_tlast(out_last), .output_axis_tuser(out_user),
    .length_min(length_min), .length_max(length_max),
    .frame_done(frame_done), .frame_len(frame_len),
    .error_short(error_short), .error_long(error_long)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic user; int cyc; } beat_t;
  typedef struct { int len; logic s; logic l; } stat_t;
  typedef struct {
    int min; int max; int len; int base; bit tu;
    int exp_beats; bit exp_user; bit exp_short; bit exp_long; int exp_len;
  } vec_t;

  beat_t outq[$];
  stat_t stq[$];
  int    cyc = 0;
  int    checks = 0, errors = 0;
  bit    bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int    bp_idx = 0;

  // Everything is sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid && out_ready) outq.push_back('{out_data, out_last, out_user, cyc});
      if (frame_done) stq.push_back('{int'(frame_len), error_short, error_long});
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? bp_pat[bp_idx] : 1'b1;
    bp_idx    = (bp_idx + 1) % 4;
  end

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int t;
    in_data = d; in_last = l; in_user = u; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int base, input bit tu);
    for (int i = 1; i <= len; i++)
      send_beat(8'(base + i - 1), logic'(i == len), logic'(tu && i == len));
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compares the collected queues to one frame's expected result, then clears them.
  task automatic check_frame(input string nm, input int exp_beats, input int base,
                             input bit exp_user, input bit exp_short, input bit exp_long,
                             input int exp_len);
    int bad, nlast;
    bad = 0; nlast = 0;
    check_eq({nm, ".beats"}, outq.size(), exp_beats);
    foreach (outq[i]) begin
      if (outq[i].data != 8'(base + i)) bad++;
      if (outq[i].last) nlast++;
    end
    check_eq({nm, ".data"}, bad, 0);
    check_eq({nm, ".nlast"}, nlast, 1);
    if (outq.size() > 0) begin
      check_eq({nm, ".final_last"}, int'(outq[$].last), 1);
      check_eq({nm, ".tuser"}, int'(outq[$].user), int'(exp_user));
    end
    check_eq({nm, ".ndone"}, stq.size(), 1);
    if (stq.size() > 0) begin
      check_eq({nm, ".len"}, stq[0].len, exp_len);
      check_eq({nm, ".short"}, int'(stq[0].s), int'(exp_short));
      check_eq({nm, ".long"}, int'(stq[0].l), int'(exp_long));
    end
    outq.delete();
    stq.delete();
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    check_eq({nm, ".tvalid"}, int'(out_valid), 0);
    check_eq({nm, ".tdata"}, int'(out_data), 0);
    check_eq({nm, ".tlast"}, int'(out_last), 0);
    check_eq({nm, ".tuser"}, int'(out_user), 0);
    check_eq({nm, ".done"}, int'(frame_done), 0);
    check_eq({nm, ".len"}, int'(frame_len), 0);
    check_eq({nm, ".errs"}, int'(error_short) + int'(error_long), 0);
    check_eq({nm, ".in_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[11];
  int   gaps;

  initial begin
    //            min max len base tu  beats user short long len
    vecs[0]  = '{4,  8,  6,  8'h10, 0, 6,  0, 0, 0, 6};
    vecs[1]  = '{4,  8,  3,  8'h20, 0, 3,  1, 1, 0, 3};
    vecs[2]  = '{4,  8,  12, 8'h30, 0, 8,  1, 0, 1, 8};
    vecs[3]  = '{4,  8,  8,  8'h40, 0, 8,  0, 0, 0, 8};
    vecs[4]  = '{4,  8,  4,  8'h50, 0, 4,  0, 0, 0, 4};
    vecs[5]  = '{0,  0,  20, 8'h60, 0, 20, 0, 0, 0, 20};
    vecs[6]  = '{1,  0,  1,  8'h80, 0, 1,  0, 0, 0, 1};
    vecs[7]  = '{10, 5,  7,  8'h90, 0, 5,  1, 0, 1, 5};
    vecs[8]  = '{4,  8,  2,  8'hA0, 1, 2,  1, 1, 0, 2};
    vecs[9]  = '{2,  1,  3,  8'hB0, 0, 1,  1, 0, 1, 1};
    vecs[10] = '{4,  8,  5,  8'hC0, 1, 5,  1, 0, 0, 5};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    // One-cycle latency: the beat is visible right after its handshake edge.
    length_min = 16'd0; length_max = 16'd0;
    send_beat(8'hA5, 1'b1, 1'b0);
    check_eq("latency.tvalid", int'(out_valid), 1);
    check_eq("latency.tdata", int'(out_data), 8'hA5);
    drain(4);
    check_frame("latency", 1, 8'hA5, 0, 0, 0, 1);

    foreach (vecs[k]) begin
      length_min = 16'(vecs[k].min);
      length_max = 16'(vecs[k].max);
      send_frame(vecs[k].len, vecs[k].base, vecs[k].tu);
      drain(4);
      check_frame($sformatf("vec%0d", k), vecs[k].exp_beats, vecs[k].base,
                  vecs[k].exp_user, vecs[k].exp_short, vecs[k].exp_long, vecs[k].exp_len);
    end

    // Exact-max frame followed back-to-back by a 4-beat frame: no bubble between them.
    length_min = 16'd4; length_max = 16'd8;
    send_frame(8, 8'h00, 1'b0);
    send_frame(4, 8'h08, 1'b0);
    drain(4);
    gaps = 0;
    for (int i = 1; i < outq.size(); i++)
      if (outq[i].cyc != outq[i-1].cyc + 1) gaps++;
    check_eq("b2b.beats", outq.size(), 12);
    check_eq("b2b.gaps", gaps, 0);
    check_eq("b2b.ndone", stq.size(), 2);
    if (stq.size() == 2) begin
      check_eq("b2b.len0", stq[0].len, 8);
      check_eq("b2b.len1", stq[1].len, 4);
      check_eq("b2b.errs", int'(stq[0].s) + int'(stq[0].l) + int'(stq[1].s) + int'(stq[1].l), 0);
    end
    outq.delete(); stq.delete();

    // Limits edited after the first beat must not affect the frame in flight.
    length_min = 16'd4; length_max = 16'd8;
    send_beat(8'hD0, 1'b0, 1'b0);
    length_min = 16'd10; length_max = 16'd2;
    for (int i = 1; i < 6; i++) send_beat(8'(8'hD0 + i), logic'(i == 5), 1'b0);
    drain(4);
    check_frame("midlimit", 6, 8'hD0, 0, 0, 0, 6);

    // Backpressure 1,0,0,1 with input tuser on the last beat.
    length_min = 16'd4; length_max = 16'd8;
    bp_en = 1'b1;
    send_frame(6, 8'hE0, 1'b1);
    drain(12);
    bp_en = 1'b0;
    drain(2);
    check_frame("backpressure", 6, 8'hE0, 1, 0, 0, 6);

    // Reset while swallowing the tail of a truncated frame.
    for (int i = 1; i <= 9; i++) send_beat(8'(8'h70 + i - 1), 1'b0, 1'b0);
    in_data = 8'h79; in_last = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    outq.delete(); stq.delete();
    check_idle("rst_trunc");
    send_frame(5, 8'h30, 1'b0);
    drain(4);
    check_frame("after_rst", 5, 8'h30, 0, 0, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_frame_length_filter.md
# axis_frame_length_filter

AXI4-Stream frame length policer placed directly upstream of the frame FIFO. Counts beats per frame, truncates frames longer than `length_max`, and flags frames shorter than `length_min` or that were truncated by asserting `tuser` on the final beat, so the frame FIFO discards them. Adds one register stage, sustains one beat per cycle, and emits per-frame status pulses for statistics counters.

## Interface
- `DATA_WIDTH`, default 8: tdata width.
- `LEN_WIDTH`, default 16: width of the beat counter and the length limits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `input_axis_tdata`  in  DATA_WIDTH  input data.
- `input_axis_tvalid`  in  1  input valid.
- `input_axis_tready`  out  1  input ready.
- `input_axis_tlast`  in  1  input end of frame.
- `input_axis_tuser`  in  1  input bad-frame flag, sampled on the tlast beat.
- `output_axis_tdata`  out  DATA_WIDTH  output data (registered).
- `output_axis_tvalid`  out  1  output valid.
- `output_axis_tready`  in  1  output ready.
- `output_axis_tlast`  out  1  output end of frame.
- `output_axis_tuser`  out  1  output bad-frame flag, meaningful only with tlast.
- `length_min`  in  LEN_WIDTH  minimum legal beats per frame. 0 or 1 disables the check.
- `length_max`  in  LEN_WIDTH  maximum beats per frame. 0 disables the check.
- `frame_done`  out  1  one-cycle pulse per frame emitted.
- `frame_len`  out  LEN_WIDTH  beats emitted for the last frame. Held until the next `frame_done`.
- `error_short`  out  1  pulse with `frame_done`: the frame was short.
- `error_long`  out  1  pulse with `frame_done`: the frame was truncated.

## Operation
- **States:** PASS and TRUNC. Reset enters PASS.
- **Beat counter:**
  - `cnt` is the 1-based index of the current input beat. It is set to 1 on the first beat of a frame and incremented on each accepted beat.
  - `cnt` saturates at 2^LEN_WIDTH−1.
- **Limit capture:** `length_min` and `length_max` are captured on the first beat of each frame. Changing them mid-frame has no effect until the next frame.
- **PASS, accepted beat, no truncation:**
  - The beat is copied to the output register.
  - `output_axis_tuser` = `input_axis_tuser` OR `short`, where `short` = `tlast` AND `min` > 1 AND `cnt` < `min`.
- **PASS, truncation:**
  - Condition: `max` ≠ 0, `cnt` == `max`, and `tlast` = 0.
  - The beat is emitted with `tlast` = 1 and `tuser` = 1, and the state moves to TRUNC.
  - If the beat also has `tlast` = 1, no truncation occurs; the frame ends normally.
- **TRUNC:**
  - `input_axis_tready` = 1 regardless of the output.
  - Input beats are discarded and the output register is not loaded.
  - The input `tlast` beat returns the state to PASS; the next beat starts a new frame.
- **Priority when both checks fire:** long wins over short. For example, with `max` < `min`, the frame is truncated and `error_long` = 1, `error_short` = 0.
- **Status:**
  - In the cycle after the output register is loaded with a `tlast` beat, `frame_done` = 1.
  - `frame_len` = `cnt` of that beat.
  - The error flags are set per the rules above.

## Timing
- **Latency:** 1 cycle from input acceptance to `output_axis_tvalid`.
- **Throughput:** 1 beat/cycle when `output_axis_tready` = 1.
- **Ready in PASS:** `input_axis_tready` = `output_axis_tready` OR NOT `output_axis_tvalid`. The combinational path from `output_axis_tready` to `input_axis_tready` is permitted.
- **Output register:**
  - Loads when `input_axis_tvalid` AND `input_axis_tready` in PASS.
  - `output_axis_tvalid` clears when the held beat is taken and nothing new is loaded.
- **Stability:** tdata/tlast/tuser/tvalid are stable while tvalid = 1 and tready = 0.
- **Reset values:** `output_axis_tvalid`, tdata, tlast, tuser, `frame_done`, `frame_len`, `error_short`, `error_long` are all 0. `input_axis_tready` is 1 in the first cycle after reset.
- **Reset mid-frame:**
  - The output register contents are dropped and the state returns to PASS.
  - The next accepted beat is treated as a first beat.
  - No `frame_done` is emitted for the interrupted frame.

## Structure
- State encoding is localparams in this module. No shared package is needed; the AXIS port set matches the frame FIFO.
- No sub-module. The output register, counter and FSM live in this one module, about 150–200 lines.

## Test plan
- **Normal frame.** Setup: `min`=4, `max`=8, 6-beat frame, `output_axis_tready`=1. Required: 6 beats out with 1-cycle latency, `tlast` on beat 6 with `tuser`=0, `frame_done` with `frame_len`=6, both errors 0.
- **Short frame.** Setup: 3-beat frame. Required: 3 beats out, beat 3 has `tlast`=1 and `tuser`=1, `error_short`=1, `frame_len`=3.
- **Long frame.** Setup: 12-beat frame. Required: 8 beats out, beat 8 has `tlast`=1 and `tuser`=1; input beats 9–12 accepted with `tready`=1 and not emitted; `error_long`=1, `frame_len`=8.
- **Exact-max boundary.** Setup: 8-beat frame with `tlast` on beat 8, then a 4-beat frame back-to-back. Required: no truncation and no errors, `frame_len` 8 then 4, no bubble between frames.
- **Backpressure.** Setup: `output_axis_tready` pattern 1,0,0,1 repeating over a 6-beat frame, plus `input_axis_tuser`=1 on the last beat. Required: data is order-preserving with no loss or duplication, output `tuser`=1 on beat 6, both errors 0.
- **Reset in TRUNC.** Setup: assert `rst` during beat 10 of a 12-beat frame, then send a 5-beat frame. Required: all outputs 0 after reset, the 5-beat frame passes clean with `frame_len`=5.
